// File: rtl/rr_mux_nch.sv
// Purpose : NCH-channel valid/ready mux into a one-entry output register, fixed-select or round-robin.
// Latency : 1 clock from in_ready/in_valid handshake to out_valid; 1 word/clock while out_ready=1.
// Backpr. : out_valid & !out_ready freezes output, drops all in_ready and holds the round-robin pointer.
//
// Ports
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   in_data/in_valid      NCH packed WIDTH-bit words, channel i at in_data[i*WIDTH +: WIDTH]
//   in_ready              one-hot (or zero) accept strobe back to the producers
//   mode, sel             0 = take channel sel, 1 = round-robin over valid channels
//   out_data/out_ch       registered word and the channel it came from
//   out_valid/out_ready   output handshake towards the single consumer
module rr_mux_nch #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    localparam int SELW = $clog2(NCH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NCH*WIDTH-1:0]   in_data,
    input  logic [NCH-1:0]         in_valid,
    output logic [NCH-1:0]         in_ready,
    input  logic                   mode,
    input  logic [SELW-1:0]        sel,
    output logic [WIDTH-1:0]       out_data,
    output logic [SELW-1:0]        out_ch,
    output logic                   out_valid,
    input  logic                   out_ready
);

    logic [WIDTH-1:0] ch_dat [NCH];
    logic [SELW-1:0]  ptr;
    logic             load_en;
    logic             grant_vld;
    logic [SELW-1:0]  grant_idx;
    logic [NCH-1:0]   grant_oh;
    logic [WIDTH-1:0] grant_dat;
    int               scan_idx;

    for (genvar g = 0; g < NCH; g++) begin : g_unpack
        assign ch_dat[g] = in_data[g*WIDTH +: WIDTH];
    end

    // The register can accept a new word when empty or when its current word leaves this cycle.
    assign load_en = !out_valid || out_ready;

    // Grant selection. Channels are compared by index rather than dynamically indexed so that an
    // out-of-range sel (NCH not a power of two) simply matches nothing.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        grant_oh  = '0;
        grant_dat = '0;
        scan_idx  = 0;
        if (!mode) begin
            for (int i = 0; i < NCH; i++) begin
                if (int'(sel) == i && in_valid[i]) begin
                    grant_vld   = 1'b1;
                    grant_idx   = SELW'(i);
                    grant_oh[i] = 1'b1;
                    grant_dat   = ch_dat[i];
                end
            end
        end else begin
            // Search starts just after the last granted channel and wraps NCH-1 -> 0;
            // the last candidate (k = NCH) is the previous winner itself.
            for (int k = 1; k <= NCH; k++) begin
                scan_idx = int'(ptr) + k;
                if (scan_idx >= NCH) begin
                    scan_idx = scan_idx - NCH;
                end
                for (int i = 0; i < NCH; i++) begin
                    if (!grant_vld && i == scan_idx && in_valid[i]) begin
                        grant_vld   = 1'b1;
                        grant_idx   = SELW'(i);
                        grant_oh[i] = 1'b1;
                        grant_dat   = ch_dat[i];
                    end
                end
            end
        end
    end

    // rst_n gates the strobe so no producer sees an accept while the block is held in reset.
    assign in_ready = (rst_n && load_en && grant_vld) ? grant_oh : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_ch    <= '0;
            out_valid <= 1'b0;
            ptr       <= SELW'(NCH - 1);
        end else if (grant_vld && load_en) begin
            out_data  <= grant_dat;
            out_ch    <= grant_idx;
            out_valid <= 1'b1;
            // Tracking the winner in fixed mode too keeps a later switch to round-robin fair.
            ptr       <= grant_idx;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
